write_back_mp: RTL and testbench
================================

Name: write_back_mp

Overview:
- Parametrised successor to the single-port write-back stage of the limb ARM-style pipeline.
- Commits data-processing results, full 64-bit long-multiply results (RdLo and RdHi) and CPSR updates, driving one or two register-file write ports.
- With one port, a long multiply takes two beats, and the block stalls the upstream stage via a ready/valid handshake.
- CPSR writes are field-masked, following MSR byte fields.

Parameters:
- DATA_W, 32, register data width.
- REG_ADDR_W, 6, register-file index width (banked register space).
- WRITE_PORTS, 1, register write ports; legal values are 1 and 2 only.
- CPSR_RESET, 32'h000000D3, CPSR value after reset (SVC mode, I=1, F=1).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- valid_i  in  1  upstream holds a valid instruction.
- ready_o  out  1  block can accept this cycle.
- dest_i  in  REG_ADDR_W  Rd, or RdLo for a long multiply.
- dest_hi_i  in  REG_ADDR_W  RdHi for a long multiply.
- write_dest_do_i  in  1  write result_i to dest_i.
- write_dest_m_i  in  1  multiply write.
- m_long_i  in  1  qualifies write_dest_m_i as a 64-bit long multiply.
- write_cpsr_i  in  1  update CPSR.
- cpsr_mask_i  in  4  byte-field enables {f,s,x,c} = bits [3:0] → CPSR bytes 3..0.
- result_i  in  DATA_W  ALU / data-out result.
- m_result_i  in  2*DATA_W  multiplier result.
- cpsr_i  in  DATA_W  new CPSR value.
- rw_we_o  out  WRITE_PORTS  per-port write enable.
- rw_i_o  out  WRITE_PORTS*REG_ADDR_W  per-port register index; port p occupies slice p.
- rw_o  out  WRITE_PORTS*DATA_W  per-port write data.
- cpsr_o  out  DATA_W  current CPSR.
- done_o  out  1  one-cycle pulse when an instruction's final write is issued.

Behaviour:
- Reset, sampled on the clk edge with rst_n=0:
  - rw_we_o=0, rw_i_o=0, rw_o=0, done_o=0, cpsr_o=CPSR_RESET, state=IDLE.
  - Reset during the HI beat discards the pending RdHi write.
- Handshake:
  - ready_o = (state==IDLE) && rst_n.
  - Accept occurs when valid_i && ready_o.
  - Inputs are sampled only on accept; when there is no accept, rw_we_o=0 next cycle.
- Latency: every write appears on the outputs one cycle after the accepting edge (registered). rw_we_o is a one-cycle pulse per write.
- Priority on accept:
  - write_dest_do_i beats write_dest_m_i; a multiply flag asserted alongside do is ignored.
  - write_cpsr_i is independent and may coincide with either register write.
- Data-processing write (do): port0 ← {dest_i, result_i}; done_o pulses.
- Short multiply (m, !m_long_i): port0 ← {dest_i, m_result_i[DATA_W-1:0]}.
- Long multiply, WRITE_PORTS=2:
  - Port0 ← {dest_i, lo} and port1 ← {dest_hi_i, hi} in the same cycle.
  - If dest_i==dest_hi_i, rw_we_o[0]=0 (RdHi wins).
- Long multiply, WRITE_PORTS=1, FSM IDLE→HI→IDLE:
  - Accept cycle: port0 ← {dest_i, lo}; latch hi and dest_hi_i; go to HI; ready_o=0.
  - HI cycle: port0 ← {dest_hi_i, hi}; return to IDLE; done_o pulses with the hi write.
  - Equal destinations: both writes are issued, and hi lands last.
- CPSR update:
  - On accept, for k=0..3, cpsr_o byte k ← cpsr_i byte k if cpsr_mask_i[k]; otherwise unchanged.
  - The update is visible the cycle after accept, including when it accompanies a long multiply.
  - A CPSR-only instruction pulses done_o with no register write.
- Accept with no write flags set: done_o pulses; no other effect.
- Unused ports (WRITE_PORTS=2, single write): rw_we_o[1]=0; rw_i_o and rw_o slices hold their previous values.

Decomposition:
- Package wb_pkg holds:
  - the state enum {WB_IDLE, WB_HI};
  - CPSR field-index constants (WB_CPSR_C=0, X=1, S=2, F=3);
  - the default CPSR_RESET constant.
- No sub-module; the CPSR byte-merge is a small function in wb_pkg.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles → cpsr_o=32'hD3, rw_we_o=0, ready_o=0; after release, ready_o=1.
- Data-processing write (WRITE_PORTS=1): dest_i=5, result_i=32'hDEADBEEF, do=1 → next cycle rw_we_o=1, rw_i_o=5, rw_o=DEADBEEF, done_o=1.
- Long multiply (WRITE_PORTS=1): m=1, long=1, dest 2/3, m_result=64'h11112222_33334444 → cycle+1 {2,33334444}, ready_o=0; cycle+2 {3,11112222}, done_o=1, ready_o=1; a valid_i held during the stall is accepted only in cycle+2.
- Long multiply (WRITE_PORTS=2): same stimulus → both ports written in cycle+1 with no stall; with dest_i=dest_hi_i=7 → rw_we_o=2'b10.
- Masked CPSR update: cpsr_o=D3, write_cpsr=1, cpsr_i=F00000FF, mask=4'b1000 → cpsr_o=F00000D3; then mask=4'b0001 → F00000FF.
- Reset mid-operation: assert rst_n=0 in the HI cycle → no hi write, state IDLE, cpsr_o=D3.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and helpers for the multi-port write-back stage.
package wb_pkg;

  // Write-back sequencing: IDLE accepts work, HI issues the deferred RdHi write
  typedef enum logic [0:0] {
    WB_IDLE = 1'b0,
    WB_HI   = 1'b1
  } wb_state_e;

  // CPSR byte-field positions, matching the MSR field mask {f,s,x,c}
  localparam int WB_CPSR_C = 0;
  localparam int WB_CPSR_X = 1;
  localparam int WB_CPSR_S = 2;
  localparam int WB_CPSR_F = 3;

  // SVC mode with IRQ and FIQ masked
  localparam logic [31:0] WB_CPSR_RESET = 32'h0000_00D3;

  // Replace only the CPSR bytes whose field-enable bit is set
  function automatic logic [31:0] wb_cpsr_merge(
    input logic [31:0] cur,
    input logic [31:0] nxt,
    input logic [3:0]  mask
  );
    logic [31:0] res;
    res = cur;
    if (mask[WB_CPSR_C]) res[8*WB_CPSR_C +: 8] = nxt[8*WB_CPSR_C +: 8];
    if (mask[WB_CPSR_X]) res[8*WB_CPSR_X +: 8] = nxt[8*WB_CPSR_X +: 8];
    if (mask[WB_CPSR_S]) res[8*WB_CPSR_S +: 8] = nxt[8*WB_CPSR_S +: 8];
    if (mask[WB_CPSR_F]) res[8*WB_CPSR_F +: 8] = nxt[8*WB_CPSR_F +: 8];
    return res;
  endfunction

endpackage

// File: rtl/write_back_mp.sv
// Write-back stage: commits ALU, short/long multiply and masked CPSR results
// through one or two register-file write ports. With a single port a long
// multiply is split into a LO beat and a HI beat, stalling upstream.
module write_back_mp
  import wb_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          REG_ADDR_W  = 6,
  parameter int          WRITE_PORTS = 1,   // 1 or 2 only
  parameter logic [31:0] CPSR_RESET  = WB_CPSR_RESET
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            valid_i,
  output logic                            ready_o,
  input  logic [REG_ADDR_W-1:0]           dest_i,
  input  logic [REG_ADDR_W-1:0]           dest_hi_i,
  input  logic                            write_dest_do_i,
  input  logic                            write_dest_m_i,
  input  logic                            m_long_i,
  input  logic                            write_cpsr_i,
  input  logic [3:0]                      cpsr_mask_i,
  input  logic [DATA_W-1:0]               result_i,
  input  logic [2*DATA_W-1:0]             m_result_i,
  input  logic [DATA_W-1:0]               cpsr_i,
  output logic [WRITE_PORTS-1:0]          rw_we_o,
  output logic [WRITE_PORTS*REG_ADDR_W-1:0] rw_i_o,
  output logic [WRITE_PORTS*DATA_W-1:0]   rw_o,
  output logic [DATA_W-1:0]               cpsr_o,
  output logic                            done_o
);

  // Slice used for RdHi in the dual-port case; folds to 0 when only one port
  // exists so the never-taken dual-port branch still indexes in range.
  localparam int HI_PORT = (WRITE_PORTS == 2) ? 1 : 0;

  wb_state_e                         r_state;
  logic [WRITE_PORTS-1:0]            r_we;
  logic [WRITE_PORTS*REG_ADDR_W-1:0] r_idx;
  logic [WRITE_PORTS*DATA_W-1:0]     r_data;
  logic                              r_done;
  logic [DATA_W-1:0]                 r_cpsr;
  logic [DATA_W-1:0]                 r_hi_data;
  logic [REG_ADDR_W-1:0]             r_hi_dest;

  logic                              w_accept;
  logic [DATA_W-1:0]                 w_lo;
  logic [DATA_W-1:0]                 w_hi;
  logic [DATA_W-1:0]                 w_cpsr_merged;

  assign ready_o       = (r_state == WB_IDLE) && rst_n;
  assign w_accept      = valid_i && ready_o;
  assign w_lo          = m_result_i[DATA_W-1:0];
  assign w_hi          = m_result_i[2*DATA_W-1:DATA_W];
  assign w_cpsr_merged = DATA_W'(wb_cpsr_merge(32'(r_cpsr), 32'(cpsr_i), cpsr_mask_i));

  assign rw_we_o = r_we;
  assign rw_i_o  = r_idx;
  assign rw_o    = r_data;
  assign cpsr_o  = r_cpsr;
  assign done_o  = r_done;

  // Sequencer: registers every write one cycle after acceptance; write enables
  // and done are single-cycle pulses, address/data slices hold when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= WB_IDLE;
      r_we      <= '0;
      r_idx     <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_cpsr    <= DATA_W'(CPSR_RESET);
      r_hi_data <= '0;
      r_hi_dest <= '0;
    end else begin
      r_we   <= '0;
      r_done <= 1'b0;
      case (r_state)
        WB_IDLE: begin
          if (w_accept) begin
            if (write_cpsr_i) begin
              r_cpsr <= w_cpsr_merged;
            end
            if (write_dest_do_i) begin
              // Data-processing result outranks any multiply flag
              r_we[0]                   <= 1'b1;
              r_idx[0 +: REG_ADDR_W]    <= dest_i;
              r_data[0 +: DATA_W]       <= result_i;
              r_done                    <= 1'b1;
            end else if (write_dest_m_i && m_long_i && (WRITE_PORTS == 2)) begin
              // Both halves in one beat; RdHi wins when the indices collide
              r_we[0]                                 <= (dest_i != dest_hi_i);
              r_idx[0 +: REG_ADDR_W]                  <= dest_i;
              r_data[0 +: DATA_W]                     <= w_lo;
              r_we[HI_PORT]                           <= 1'b1;
              r_idx[HI_PORT*REG_ADDR_W +: REG_ADDR_W] <= dest_hi_i;
              r_data[HI_PORT*DATA_W +: DATA_W]        <= w_hi;
              r_done                                  <= 1'b1;
            end else if (write_dest_m_i && m_long_i) begin
              // Single port: issue RdLo now, park RdHi for the next beat
              r_we[0]                <= 1'b1;
              r_idx[0 +: REG_ADDR_W] <= dest_i;
              r_data[0 +: DATA_W]    <= w_lo;
              r_hi_data              <= w_hi;
              r_hi_dest              <= dest_hi_i;
              r_state                <= WB_HI;
            end else if (write_dest_m_i) begin
              r_we[0]                <= 1'b1;
              r_idx[0 +: REG_ADDR_W] <= dest_i;
              r_data[0 +: DATA_W]    <= w_lo;
              r_done                 <= 1'b1;
            end else begin
              // CPSR-only or empty instruction still retires
              r_done <= 1'b1;
            end
          end
        end
        WB_HI: begin
          r_we[0]                <= 1'b1;
          r_idx[0 +: REG_ADDR_W] <= r_hi_dest;
          r_data[0 +: DATA_W]    <= r_hi_data;
          r_done                 <= 1'b1;
          r_state                <= WB_IDLE;
        end
        default: r_state <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_back_mp.sv
// Randomised self-checking bench for write_back_mp, covering the single-port
// (two-beat long multiply) and dual-port builds against a cycle-level model.
module tb_write_back_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, do_f, m_f, long_f, wc_f;
  logic [3:0]  mask;
  logic [5:0]  dest, dest_hi;
  logic [31:0] result, cpsr_in;
  logic [63:0] mres;
  int          act = 1;
  logic        v1, v2;

  logic [0:0]  we1;
  logic [5:0]  ri1;
  logic [31:0] ro1, cpsr1;
  logic        rdy1, done1;
  logic [1:0]  we2;
  logic [11:0] ri2;
  logic [63:0] ro2;
  logic [31:0] cpsr2;
  logic        rdy2, done2;

  logic [1:0]  obs_we;
  logic [5:0]  obs_i0, obs_i1;
  logic [31:0] obs_d0, obs_d1, obs_cpsr;
  logic        obs_ready, obs_done;

  // reference model state
  logic [31:0] m_cpsr;
  logic        m_pend;
  logic [5:0]  m_hd;
  logic [31:0] m_hdat;
  logic [1:0]  exp_we;
  logic [5:0]  exp_i0, exp_i1;
  logic [31:0] exp_d0, exp_d1;
  logic        exp_done, exp_rst;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign v1 = (act == 1) && valid;
  assign v2 = (act == 2) && valid;

  write_back_mp #(.WRITE_PORTS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .valid_i(v1), .ready_o(rdy1),
    .dest_i(dest), .dest_hi_i(dest_hi), .write_dest_do_i(do_f),
    .write_dest_m_i(m_f), .m_long_i(long_f), .write_cpsr_i(wc_f),
    .cpsr_mask_i(mask), .result_i(result), .m_result_i(mres), .cpsr_i(cpsr_in),
    .rw_we_o(we1), .rw_i_o(ri1), .rw_o(ro1), .cpsr_o(cpsr1), .done_o(done1)
  );

  write_back_mp #(.WRITE_PORTS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .valid_i(v2), .ready_o(rdy2),
    .dest_i(dest), .dest_hi_i(dest_hi), .write_dest_do_i(do_f),
    .write_dest_m_i(m_f), .m_long_i(long_f), .write_cpsr_i(wc_f),
    .cpsr_mask_i(mask), .result_i(result), .m_result_i(mres), .cpsr_i(cpsr_in),
    .rw_we_o(we2), .rw_i_o(ri2), .rw_o(ro2), .cpsr_o(cpsr2), .done_o(done2)
  );

  // present whichever build is under test through one set of observation signals
  always_comb begin
    obs_we    = (act == 2) ? we2 : {1'b0, we1};
    obs_i0    = (act == 2) ? ri2[5:0] : ri1;
    obs_i1    = ri2[11:6];
    obs_d0    = (act == 2) ? ro2[31:0] : ro1;
    obs_d1    = ro2[63:32];
    obs_cpsr  = (act == 2) ? cpsr2 : cpsr1;
    obs_ready = (act == 2) ? rdy2 : rdy1;
    obs_done  = (act == 2) ? done2 : done1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s (wp=%0d t=%0t): got %h expected %h", tag, act, $time, obs, exp);
    end
  endtask

  // Predict what the outputs show after the coming edge, from the inputs now applied
  task automatic model_step();
    logic [31:0] lo, hi;
    lo = mres[31:0];
    hi = mres[63:32];
    exp_we = 2'b00; exp_done = 1'b0; exp_rst = 1'b0;
    if (!rst_n) begin
      m_cpsr = 32'h0000_00D3; m_pend = 1'b0; exp_rst = 1'b1;
      exp_i0 = '0; exp_i1 = '0; exp_d0 = '0; exp_d1 = '0;
    end else if (m_pend) begin
      exp_we = 2'b01; exp_i0 = m_hd; exp_d0 = m_hdat; exp_done = 1'b1; m_pend = 1'b0;
    end else if (valid) begin
      $display("txn t=%0t wp=%0d do=%0b m=%0b long=%0b wcpsr=%0b mask=%h dest=%0d/%0d",
               $time, act, do_f, m_f, long_f, wc_f, mask, dest, dest_hi);
      if (wc_f)
        for (int k = 0; k < 4; k++)
          if (mask[k]) m_cpsr[8*k +: 8] = cpsr_in[8*k +: 8];
      if (do_f) begin
        exp_we = 2'b01; exp_i0 = dest; exp_d0 = result; exp_done = 1'b1;
      end else if (m_f && !long_f) begin
        exp_we = 2'b01; exp_i0 = dest; exp_d0 = lo; exp_done = 1'b1;
      end else if (m_f && act == 2) begin
        exp_we = (dest == dest_hi) ? 2'b10 : 2'b11;
        exp_i0 = dest; exp_d0 = lo; exp_i1 = dest_hi; exp_d1 = hi; exp_done = 1'b1;
      end else if (m_f) begin
        exp_we = 2'b01; exp_i0 = dest; exp_d0 = lo;
        m_pend = 1'b1; m_hd = dest_hi; m_hdat = hi;
      end else begin
        exp_done = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("we", obs_we, exp_we);
    chk("done", obs_done, exp_done);
    chk("cpsr", obs_cpsr, m_cpsr);
    chk("ready", obs_ready, !m_pend && rst_n);
    if (exp_rst) begin
      chk("rst_idx0", obs_i0, 0);
      chk("rst_data0", obs_d0, 0);
      if (act == 2) begin
        chk("rst_idx1", obs_i1, 0);
        chk("rst_data1", obs_d1, 0);
      end
    end else begin
      if (exp_we[0]) begin
        chk("idx0", obs_i0, exp_i0);
        chk("data0", obs_d0, exp_d0);
      end
      if (exp_we[1]) begin
        chk("idx1", obs_i1, exp_i1);
        chk("data1", obs_d1, exp_d1);
      end
    end
  endtask

  task automatic clear();
    valid = 0; do_f = 0; m_f = 0; long_f = 0; wc_f = 0; mask = 0;
    dest = 0; dest_hi = 0; result = 0; mres = 0; cpsr_in = 0;
  endtask

  task automatic do_reset();
    clear();
    rst_n = 1'b0;
    cycle();
    cycle();
    chk("rst_cpsr_const", obs_cpsr, 32'h0000_00D3);
    chk("rst_ready_low", obs_ready, 1'b0);
    rst_n = 1'b1;
    cycle();
    chk("ready_after_rst", obs_ready, 1'b1);
  endtask

  task automatic long_mul(input logic [5:0] lo_d, input logic [5:0] hi_d);
    clear();
    valid = 1; m_f = 1; long_f = 1; dest = lo_d; dest_hi = hi_d;
    mres = 64'h1111_2222_3333_4444;
  endtask

  task automatic rnd(input int n);
    for (int i = 0; i < n; i++) begin
      rst_n   = ($urandom_range(0, 49) != 0);
      valid   = ($urandom_range(0, 3) != 0);
      do_f    = ($urandom_range(0, 3) == 0);
      m_f     = 1'($urandom_range(0, 1));
      long_f  = 1'($urandom_range(0, 1));
      wc_f    = ($urandom_range(0, 2) == 0);
      mask    = 4'($urandom);
      dest    = 6'($urandom);
      dest_hi = ($urandom_range(0, 3) == 0) ? dest : 6'($urandom);
      result  = $urandom;
      mres    = {$urandom, $urandom};
      cpsr_in = $urandom;
      cycle();
    end
    rst_n = 1'b1;
    clear();
    cycle();
    cycle();
  endtask

  initial begin
    m_cpsr = 32'h0000_00D3; m_pend = 1'b0; m_hd = '0; m_hdat = '0;
    exp_i0 = '0; exp_i1 = '0; exp_d0 = '0; exp_d1 = '0;
    clear();
    rst_n = 1'b0;
    @(negedge clk);

    // ---------------- single write port ----------------
    act = 1;
    do_reset();

    clear(); valid = 1; do_f = 1; dest = 5; result = 32'hDEADBEEF;
    cycle();
    chk("dp_idx", obs_i0, 5);
    chk("dp_data", obs_d0, 32'hDEADBEEF);
    chk("dp_done", obs_done, 1'b1);

    long_mul(2, 3);
    cycle();
    chk("lmul_lo_idx", obs_i0, 2);
    chk("lmul_lo_data", obs_d0, 32'h3333_4444);
    chk("lmul_stall", obs_ready, 1'b0);
    // new instruction held valid across the stall
    do_f = 1; m_f = 0; long_f = 0; dest = 9; result = 32'h55;
    cycle();
    chk("lmul_hi_idx", obs_i0, 3);
    chk("lmul_hi_data", obs_d0, 32'h1111_2222);
    chk("lmul_hi_done", obs_done, 1'b1);
    cycle();
    chk("held_accept_idx", obs_i0, 9);

    long_mul(6, 6);
    cycle();
    cycle();
    chk("lmul_eq_hi_last", obs_d0, 32'h1111_2222);

    clear(); valid = 1; wc_f = 1; cpsr_in = 32'hF000_00FF; mask = 4'b1000;
    cycle();
    chk("cpsr_f_field", obs_cpsr, 32'hF000_00D3);
    chk("cpsr_only_done", obs_done, 1'b1);
    mask = 4'b0001;
    cycle();
    chk("cpsr_c_field", obs_cpsr, 32'hF000_00FF);

    long_mul(4, 5);
    cycle();
    clear(); rst_n = 1'b0;
    cycle();
    chk("midhi_rst_we", obs_we, 2'b00);
    chk("midhi_rst_cpsr", obs_cpsr, 32'h0000_00D3);
    rst_n = 1'b1;
    cycle();
    chk("no_late_hi", obs_we, 2'b00);

    rnd(300);

    // ---------------- dual write ports ----------------
    act = 2;
    do_reset();

    long_mul(2, 3);
    cycle();
    chk("dual_we", obs_we, 2'b11);
    chk("dual_hi_data", obs_d1, 32'h1111_2222);
    chk("dual_no_stall", obs_ready, 1'b1);
    long_mul(7, 7);
    cycle();
    chk("dual_eq_we", obs_we, 2'b10);
    clear();
    cycle();

    rnd(300);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
